ahb_sram_subordinate: RTL and testbench



---
 rtl/ahb_pkg.sv | 33 +++
 rtl/ahb_sram_subordinate_if.sv | 34 +++
 rtl/ahb_lane_mask.sv | 21 ++
 rtl/ahb_sram_subordinate.sv | 128 ++++++++++++
 tb/tb_ahb_sram_subordinate.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the SRAM subordinate state type.
package ahb_pkg;

  typedef enum logic [2:0] {
    TRANS_IDLE   = 3'd0,
    TRANS_BUSY   = 3'd1,
    TRANS_NONSEQ = 3'd2,
    TRANS_SEQ    = 3'd3
  } trans_t;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'd0,
    RESP_ERROR = 2'd1
  } resp_t;

  localparam logic [3:0] SIZE_BYTE  = 4'd0;
  localparam logic [3:0] SIZE_HALF  = 4'd1;
  localparam logic [3:0] SIZE_WORD  = 4'd2;
  localparam logic [3:0] SIZE_DWORD = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  function automatic logic trans_active(input logic [2:0] t);
    return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_sram_subordinate_if.sv
// AHB subordinate port bundle between the fabric (master) and the SRAM (slave).
interface ahb_sram_subordinate_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);

  // Handshake: an address phase is taken at a rising edge where ready, sel and
  // an active trans (NONSEQ/SEQ) coincide; its data phase ends at the first
  // rising edge where readyOut (fed back as ready) is high.
  logic [AddrWidth-1:0] addr;
  logic                 write;
  logic [3:0]           size;
  logic [2:0]           burst;
  logic [3:0]           prot;
  logic [2:0]           trans;
  logic                 mastLock;
  logic                 ready;
  logic                 sel;
  logic [DataWidth-1:0] wData;
  logic                 readyOut;
  logic [1:0]           resp;
  logic [DataWidth-1:0] rData;

  modport master (
    output addr, write, size, burst, prot, trans, mastLock, ready, sel, wData,
    input  readyOut, resp, rData
  );

  modport slave (
    input  addr, write, size, burst, prot, trans, mastLock, ready, sel, wData,
    output readyOut, resp, rData
  );

endinterface

// File: rtl/ahb_lane_mask.sv
// Byte-enable mask for one AHB beat: a lane is active when it shares the
// same size-aligned block as the transfer address.
module ahb_lane_mask #(
  parameter int DataWidth = 32
) (
  input  logic [3:0]                     size,
  input  logic [$clog2(DataWidth/8)-1:0] addr_lo,
  output logic [DataWidth/8-1:0]         mask
);

  localparam int LaneBytes = DataWidth / 8;
  localparam int LaneBits  = $clog2(LaneBytes);

  always_comb begin
    mask = '0;
    for (int i = 0; i < LaneBytes; i++) begin
      mask[i] = (((LaneBits'(i) ^ addr_lo) >> size) == '0);
    end
  end

endmodule

// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate backed by a byte-addressable SRAM with programmable wait
// states and a two-cycle ERROR response for illegal transfers.
module ahb_sram_subordinate
  import ahb_pkg::*;
#(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 32,
  parameter int MemBytes   = 4096,
  parameter int WaitStates = 0
) (
  input  logic                   clk,
  input  logic                   nReset,
  ahb_sram_subordinate_if.slave  bus,
  output state_t                 dbg_state
);

  localparam int LaneBytes = DataWidth / 8;
  localparam int LaneBits  = $clog2(LaneBytes);
  localparam int IdxBits   = $clog2(MemBytes);
  localparam int Depth     = MemBytes / LaneBytes;

  state_t               state;
  logic [3:0]           cnt;
  logic                 ready_q;
  resp_t                resp_q;
  logic                 cap_write;
  logic [3:0]           cap_size;
  logic [IdxBits-1:0]   cap_addr;

  logic [DataWidth-1:0] mem [Depth];

  logic                 accept;
  logic                 err_in;
  logic [AddrWidth-1:0] align_m;
  logic [LaneBytes-1:0] lane_mask;
  logic [IdxBits-LaneBits-1:0] word_idx;
  logic                 unused_sig;

  assign accept  = bus.ready & bus.sel & trans_active(bus.trans);
  assign align_m = (AddrWidth'(1) << bus.size) - AddrWidth'(1);
  assign err_in  = (bus.size > 4'(LaneBits))
                 | (|(bus.addr & align_m))
                 | (bus.addr >= AddrWidth'(MemBytes));

  // burst, prot and mastLock carry no meaning for a flat SRAM.
  assign unused_sig = ^{bus.burst, bus.prot, bus.mastLock};

  assign word_idx = cap_addr[IdxBits-1:LaneBits];

  always_ff @(posedge clk) begin
    if (!nReset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= RESP_OKAY;
    end else begin
      unique case (state)
        // DATA and ERR2 complete this cycle, so they may launch the next transfer.
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (accept) begin
            cap_write <= bus.write;
            cap_size  <= bus.size;
            cap_addr  <= bus.addr[IdxBits-1:0];
            if (err_in) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= RESP_ERROR;
            end else if (WaitStates > 0) begin
              state   <= ST_WAIT;
              cnt     <= 4'(WaitStates - 1);
              ready_q <= 1'b0;
              resp_q  <= RESP_OKAY;
            end else begin
              state   <= ST_DATA;
              ready_q <= 1'b1;
              resp_q  <= RESP_OKAY;
            end
          end else begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state   <= ST_DATA;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          resp_q  <= RESP_OKAY;
        end
      endcase
    end
  end

  ahb_lane_mask #(.DataWidth(DataWidth)) u_lane_mask (
    .size    (cap_size),
    .addr_lo (cap_addr[LaneBits-1:0]),
    .mask    (lane_mask)
  );

  // A write held in DATA while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (nReset && (state == ST_DATA) && cap_write) begin
      for (int i = 0; i < LaneBytes; i++) begin
        if (lane_mask[i]) begin
          mem[word_idx][i*8 +: 8] <= bus.wData[i*8 +: 8];
        end
      end
    end
  end

  assign bus.readyOut = ready_q;
  assign bus.resp     = resp_q;
  assign bus.rData    = ((state == ST_DATA) && !cap_write) ? mem[word_idx] : '0;
  assign dbg_state    = state;

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed plus randomised bench for ahb_sram_subordinate: one zero-wait and
// one two-wait instance share the address/data bus, each with its own select.
module tb_ahb_sram_subordinate;
  import ahb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4096;

  logic          clk = 1'b0;
  logic          n_reset;
  logic [AW-1:0] addr;
  logic          write;
  logic [3:0]    size;
  logic [2:0]    trans;
  logic [DW-1:0] wdata;
  logic          sel0, sel1;
  state_t        st0, st1;

  logic [33:0]   exp_q[$];
  int            total = 0;
  int            bad   = 0;

  always #5 clk = ~clk;

  ahb_sram_subordinate_if #(.DataWidth(DW), .AddrWidth(AW)) ifc0 ();
  ahb_sram_subordinate_if #(.DataWidth(DW), .AddrWidth(AW)) ifc1 ();

  assign ifc0.addr     = addr;
  assign ifc0.write    = write;
  assign ifc0.size     = size;
  assign ifc0.burst    = 3'd1;
  assign ifc0.prot     = 4'h3;
  assign ifc0.trans    = trans;
  assign ifc0.mastLock = 1'b0;
  assign ifc0.ready    = ifc0.readyOut;
  assign ifc0.sel      = sel0;
  assign ifc0.wData    = wdata;

  assign ifc1.addr     = addr;
  assign ifc1.write    = write;
  assign ifc1.size     = size;
  assign ifc1.burst    = 3'd0;
  assign ifc1.prot     = 4'h1;
  assign ifc1.trans    = trans;
  assign ifc1.mastLock = 1'b1;
  assign ifc1.ready    = ifc1.readyOut;
  assign ifc1.sel      = sel1;
  assign ifc1.wData    = wdata;

  ahb_sram_subordinate #(
    .DataWidth(DW), .AddrWidth(AW), .MemBytes(MB), .WaitStates(0)
  ) u_dut0 (
    .clk       (clk),
    .nReset    (n_reset),
    .bus       (ifc0.slave),
    .dbg_state (st0)
  );

  ahb_sram_subordinate #(
    .DataWidth(DW), .AddrWidth(AW), .MemBytes(MB), .WaitStates(2)
  ) u_dut1 (
    .clk       (clk),
    .nReset    (n_reset),
    .bus       (ifc1.slave),
    .dbg_state (st1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input int which, input string tag);
    if (which == 0) begin
      chk({tag, "_ready"}, ifc0.readyOut, 1'b1);
      chk({tag, "_resp"},  ifc0.resp, RESP_OKAY);
      chk({tag, "_rdata"}, ifc0.rData, '0);
      chk({tag, "_state"}, st0, ST_IDLE);
    end else begin
      chk({tag, "_ready"}, ifc1.readyOut, 1'b1);
      chk({tag, "_resp"},  ifc1.resp, RESP_OKAY);
      chk({tag, "_rdata"}, ifc1.rData, '0);
      chk({tag, "_state"}, st1, ST_IDLE);
    end
  endtask

  // Present an address phase; it is taken at the next rising edge.
  task automatic addr_ph(input int which, input logic [AW-1:0] a, input logic wr,
                         input logic [3:0] sz);
    sel0  = (which == 0);
    sel1  = (which == 1);
    addr  = a;
    write = wr;
    size  = sz;
    trans = ($urandom_range(0, 1) == 1) ? TRANS_SEQ : TRANS_NONSEQ;
  endtask

  // Run one data phase; returns at the falling edge where readyOut is high so
  // the caller may pipeline the next address phase.
  task automatic data_ph(input int which, input logic [DW-1:0] wd,
                         input logic [1:0] er, input logic [DW-1:0] ed,
                         input int ew, input logic [1:0] ewr);
    int            waits;
    logic          done;
    logic          ro;
    logic [1:0]    rs;
    logic [DW-1:0] rd;
    logic [33:0]   e;
    @(posedge clk);
    #1;
    trans = TRANS_IDLE;
    wdata = wd;
    exp_q.push_back({er, ed});
    waits = 0;
    done  = 1'b0;
    ro    = 1'b0;
    rs    = '0;
    rd    = '0;
    while (!done && waits <= 20) begin
      @(negedge clk);
      ro = (which == 0) ? ifc0.readyOut : ifc1.readyOut;
      rs = (which == 0) ? ifc0.resp     : ifc1.resp;
      rd = (which == 0) ? ifc0.rData    : ifc1.rData;
      if (ro) begin
        done = 1'b1;
      end else begin
        chk("wait_resp", rs, ewr);
        waits++;
        @(posedge clk);
        #1;
      end
    end
    chk("wait_count", waits, ew);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp", rs, e[33:32]);
      chk("rdata", rd, e[31:0]);
    end
  endtask

  initial begin
    logic [31:0] model [16];
    logic [31:0] v;
    int          k, sz, off, wr;

    n_reset = 1'b0;
    trans   = TRANS_IDLE;
    sel0    = 1'b0;
    sel1    = 1'b0;
    addr    = '0;
    write   = 1'b0;
    size    = '0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_out(0, "rst0");
    chk_idle_out(1, "rst1");
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    // Zero-wait back-to-back write then read of the same word.
    addr_ph(0, 32'h10, 1'b1, SIZE_WORD);
    data_ph(0, 32'hDEADBEEF, RESP_OKAY, 32'h0, 0, RESP_OKAY);
    addr_ph(0, 32'h10, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_OKAY, 32'hDEADBEEF, 0, RESP_OKAY);

    // Byte lane write then word read.
    addr_ph(0, 32'h12, 1'b1, SIZE_BYTE);
    data_ph(0, 32'h00550000, RESP_OKAY, 32'h0, 0, RESP_OKAY);
    addr_ph(0, 32'h10, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_OKAY, 32'hDE55BEEF, 0, RESP_OKAY);

    // Misaligned halfword: ERROR pair, memory unchanged, read accepted in ERR2.
    addr_ph(0, 32'h11, 1'b1, SIZE_HALF);
    data_ph(0, 32'hFFFFFFFF, RESP_ERROR, 32'h0, 1, RESP_ERROR);
    addr_ph(0, 32'h10, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_OKAY, 32'hDE55BEEF, 0, RESP_OKAY);

    // Out of range read, then a write accepted in ERR2 completes OKAY.
    addr_ph(0, 32'h1000, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_ERROR, 32'h0, 1, RESP_ERROR);
    addr_ph(0, 32'h14, 1'b1, SIZE_WORD);
    data_ph(0, 32'h0BADF00D, RESP_OKAY, 32'h0, 0, RESP_OKAY);
    addr_ph(0, 32'h16, 1'b1, SIZE_HALF);
    data_ph(0, 32'hCAFE0000, RESP_OKAY, 32'h0, 0, RESP_OKAY);
    addr_ph(0, 32'h14, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_OKAY, 32'hCAFEF00D, 0, RESP_OKAY);

    // Oversized transfer on a 32-bit bus.
    addr_ph(0, 32'h18, 1'b0, SIZE_DWORD);
    data_ph(0, 32'h0, RESP_ERROR, 32'h0, 1, RESP_ERROR);

    // BUSY with select, then NONSEQ without select: neither is captured.
    @(posedge clk);
    #1;
    sel0  = 1'b1;
    addr  = 32'h10;
    write = 1'b0;
    size  = SIZE_WORD;
    trans = TRANS_BUSY;
    @(posedge clk);
    @(negedge clk);
    chk_idle_out(0, "busy");
    sel0  = 1'b0;
    trans = TRANS_NONSEQ;
    @(posedge clk);
    @(negedge clk);
    chk_idle_out(0, "nosel");
    trans = TRANS_IDLE;
    @(posedge clk);
    #1;

    // Two wait states.
    addr_ph(1, 32'h10, 1'b1, SIZE_WORD);
    data_ph(1, 32'hDEADBEEF, RESP_OKAY, 32'h0, 2, RESP_OKAY);
    addr_ph(1, 32'h10, 1'b0, SIZE_WORD);
    data_ph(1, 32'h0, RESP_OKAY, 32'hDEADBEEF, 2, RESP_OKAY);
    addr_ph(1, 32'h20, 1'b1, SIZE_WORD);
    data_ph(1, 32'h11223344, RESP_OKAY, 32'h0, 2, RESP_OKAY);
    addr_ph(1, 32'h20, 1'b0, SIZE_WORD);
    data_ph(1, 32'h0, RESP_OKAY, 32'h11223344, 2, RESP_OKAY);
    addr_ph(1, 32'h1001, 1'b0, SIZE_HALF);
    data_ph(1, 32'h0, RESP_ERROR, 32'h0, 1, RESP_ERROR);

    // Reset while a write to 0x20 sits in WAIT.
    @(posedge clk);
    #1;
    addr_ph(1, 32'h20, 1'b1, SIZE_WORD);
    @(posedge clk);
    #1;
    trans   = TRANS_IDLE;
    wdata   = 32'hAAAAAAAA;
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_out(1, "rst_wait");
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    addr_ph(1, 32'h20, 1'b0, SIZE_WORD);
    data_ph(1, 32'h0, RESP_OKAY, 32'h11223344, 2, RESP_OKAY);

    // Reset while a write to 0x10 sits in DATA.
    @(posedge clk);
    #1;
    addr_ph(0, 32'h10, 1'b1, SIZE_WORD);
    @(posedge clk);
    #1;
    trans   = TRANS_IDLE;
    wdata   = 32'h12345678;
    n_reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_idle_out(0, "rst_data");
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    addr_ph(0, 32'h10, 1'b0, SIZE_WORD);
    data_ph(0, 32'h0, RESP_OKAY, 32'hDE55BEEF, 0, RESP_OKAY);

    // Random mixed-size traffic over a 16-word window against a lane model.
    for (int i = 0; i < 16; i++) begin
      v        = $urandom;
      model[i] = v;
      addr_ph(0, 32'h100 + 32'(i * 4), 1'b1, SIZE_WORD);
      data_ph(0, v, RESP_OKAY, 32'h0, 0, RESP_OKAY);
    end
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 15);
      sz = $urandom_range(0, 2);
      wr = $urandom_range(0, 1);
      if (sz == 0)      off = $urandom_range(0, 3);
      else if (sz == 1) off = 2 * $urandom_range(0, 1);
      else              off = 0;
      addr_ph(0, 32'h100 + 32'(k * 4 + off), wr[0], 4'(sz));
      if (wr == 1) begin
        v = $urandom;
        for (int b = 0; b < 4; b++) begin
          if (b >= off && b < off + (1 << sz)) model[k][8*b +: 8] = v[8*b +: 8];
        end
        data_ph(0, v, RESP_OKAY, 32'h0, 0, RESP_OKAY);
      end else begin
        data_ph(0, $urandom, RESP_OKAY, model[k], 0, RESP_OKAY);
      end
    end

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
